// File: rtl/coeff_ramp16_pkg.sv
// Shared constants and FSM encoding for the coefficient ramp engine.
package coeff_ramp16_pkg;
  localparam int NCH     = 16;
  localparam int COEFF_W = 16;
  localparam int COEFF_Q = 14;
  localparam int STEP    = 64;
  localparam int NSLOT   = 2 * NCH;
  localparam int SLOT_W  = $clog2(NSLOT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SWEEP  = 2'd1,
    S_FINISH = 2'd2
  } ramp_state_e;
endpackage

// File: rtl/coeff_ramp16_if.sv
// Coefficient bus between calculator/control and the ramp engine.
interface coeff_ramp16_if;
  import coeff_ramp16_pkg::*;

  logic                     coeff_done;
  logic [NCH*COEFF_W-1:0]   tgtL_flat;
  logic [NCH*COEFF_W-1:0]   tgtR_flat;
  logic                     sample_tick;
  logic                     snap;
  logic [NCH*COEFF_W-1:0]   gL_flat;
  logic [NCH*COEFF_W-1:0]   gR_flat;
  logic                     busy;
  logic                     settled;
  logic                     overrun;

  modport master (
    output coeff_done, tgtL_flat, tgtR_flat, sample_tick, snap,
    input  gL_flat, gR_flat, busy, settled, overrun
  );

  modport slave (
    input  coeff_done, tgtL_flat, tgtR_flat, sample_tick, snap,
    output gL_flat, gR_flat, busy, settled, overrun
  );
endinterface

// File: rtl/coeff_ramp16_step.sv
// One slew step: move cur toward tgt by at most STEP, never past tgt.
module coeff_step_toward #(
  parameter int COEFF_W = 16,
  parameter int STEP    = 64
) (
  input  logic signed [COEFF_W-1:0] cur,
  input  logic signed [COEFF_W-1:0] tgt,
  output logic signed [COEFF_W-1:0] nxt,
  output logic                      changed
);
  localparam logic signed [COEFF_W:0] STEP_X = (COEFF_W+1)'(STEP);

  logic signed [COEFF_W:0] d, mag, sum;

  // Difference is one bit wider so full-scale spans cannot wrap.
  always_comb begin
    d   = {tgt[COEFF_W-1], tgt} - {cur[COEFF_W-1], cur};
    mag = d[COEFF_W] ? -d : d;
    sum = {cur[COEFF_W-1], cur} + (d[COEFF_W] ? -STEP_X : STEP_X);
    if (mag <= STEP_X) nxt = tgt;
    else               nxt = sum[COEFF_W-1:0];
    changed = (nxt != cur);
  end
endmodule

// File: rtl/coeff_ramp16.sv
// Slews 32 live mixer coefficients toward loaded targets, one slot per clock per sample tick.
module coeff_ramp16
  import coeff_ramp16_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  coeff_ramp16_if.slave  bus
);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSLOT - 1);

  logic signed [COEFF_W-1:0] live   [NSLOT];
  logic signed [COEFF_W-1:0] tgt    [NSLOT];
  logic signed [COEFF_W-1:0] tgt_in [NSLOT];
  logic signed [COEFF_W-1:0] step_nxt;
  logic                      step_chg;
  logic [SLOT_W-1:0]         slot;
  ramp_state_e               state, state_d;
  logic                      pending, changed, load_seen, settled_q, overrun_q, enter;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign tgt_in[k]       = bus.tgtL_flat[k*COEFF_W +: COEFF_W];
    assign tgt_in[NCH + k] = bus.tgtR_flat[k*COEFF_W +: COEFF_W];
    assign bus.gL_flat[k*COEFF_W +: COEFF_W] = live[k];
    assign bus.gR_flat[k*COEFF_W +: COEFF_W] = live[NCH + k];
  end

  coeff_step_toward #(.COEFF_W(COEFF_W), .STEP(STEP)) u_step (
    .cur     (live[slot]),
    .tgt     (tgt[slot]),
    .nxt     (step_nxt),
    .changed (step_chg)
  );

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:   if (bus.sample_tick) state_d = S_SWEEP;
      S_SWEEP:  if (slot == LAST_SLOT) state_d = S_FINISH;
      S_FINISH: state_d = (pending || bus.sample_tick) ? S_SWEEP : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (bus.snap) state_d = S_IDLE;
  end

  assign enter = (state_d == S_SWEEP) && (state != S_SWEEP);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NSLOT; k++) begin
        live[k] <= '0;
        tgt[k]  <= '0;
      end
      slot      <= '0;
      pending   <= 1'b0;
      changed   <= 1'b0;
      load_seen <= 1'b0;
      settled_q <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      if (bus.coeff_done)
        for (int k = 0; k < NSLOT; k++) tgt[k] <= tgt_in[k];

      if (bus.snap) begin
        // Freshly arriving targets win over the stored ones on a combined snap+load.
        for (int k = 0; k < NSLOT; k++) live[k] <= bus.coeff_done ? tgt_in[k] : tgt[k];
        pending   <= 1'b0;
        settled_q <= 1'b1;
        load_seen <= 1'b0;
      end else begin
        if (state == S_SWEEP) begin
          live[slot] <= step_nxt;
          if (step_chg) changed <= 1'b1;
          slot <= slot + 1'b1;
          if (bus.sample_tick) begin
            if (pending) overrun_q <= 1'b1;
            else         pending   <= 1'b1;
          end
        end
        if (state == S_FINISH) begin
          settled_q <= !changed && !load_seen;
          if (bus.sample_tick && pending) overrun_q <= 1'b1;
          pending <= 1'b0;
        end
        if (enter) begin
          slot      <= '0;
          changed   <= 1'b0;
          load_seen <= 1'b0;
        end
        // A load that coincides with sweep entry is fully covered by that sweep.
        if (bus.coeff_done) begin
          settled_q <= 1'b0;
          if (!enter) load_seen <= 1'b1;
        end
      end
    end
  end

  assign bus.busy    = (state != S_IDLE);
  assign bus.settled = settled_q;
  assign bus.overrun = overrun_q;
endmodule
